// File: rtl/pulse_stretch_led_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretch_led_pkg
// Shared definitions for the LED pulse stretcher: FSM state encodings and a
// helper that sizes the phase counter.
// -----------------------------------------------------------------------------
package pulse_stretch_led_pkg;

    // FSM state encodings shared by every file of the block
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Width that can hold max(on_t, gap_t). The limit value itself is passed
    // to the counter, so the width must cover the limit, not just limit-1.
    function automatic int cnt_width(input int on_t, input int gap_t);
        int m;
        m = (on_t > gap_t) ? on_t : gap_t;
        return (m <= 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulse_stretch_led_hold_counter.sv
// -----------------------------------------------------------------------------
// hold_counter
// Up-counter used to time both the ON and the GAP phase of the stretcher.
// Counts from 0 while enabled, clears on load, and flags the final cycle of
// the phase (count == limit-1).
//
// Ports
//   clk      in  1  clock, rising edge
//   rst_n    in  1  synchronous active-low reset
//   i_en     in  1  count enable
//   i_load   in  1  clear count to 0 (has priority over i_en)
//   i_limit  in  W  phase length in cycles (>=1)
//   o_last   out 1  count has reached limit-1
// -----------------------------------------------------------------------------
module hold_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_limit,
    output logic         o_last
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_last = (r_count == (i_limit - W'(1)));

endmodule

// File: rtl/pulse_stretch_led.sv
// -----------------------------------------------------------------------------
// pulse_stretch_led
// Stretches single-cycle event pulses into visible LED ON windows, each
// followed by a forced OFF gap. Events arriving while a window or gap is
// running are queued in a saturating counter so every event is shown.
//
// Ports
//   clk_200H  in  1   system clock (200 Hz), rising edge
//   rst_n     in  1   synchronous active-low reset
//   pulse_in  in  1   event strobe, one cycle wide
//   led_out   out 1   stretched LED drive (registered)
//   busy      out 1   high in ON or GAP (registered)
//   pending   out PW  queued events not yet displayed
//   overflow  out 1   sticky: an event was dropped with the queue full
//   ovf_clr   in  1   clears overflow (only with PULSE_STRETCH_OVF_CLR_EN)
//
// Build option
//   PULSE_STRETCH_OVF_CLR_EN  adds the ovf_clr input; without it overflow
//                             clears only on reset.
//
// States
//   ST_IDLE | waiting for an event, LED off
//   ST_ON   | LED on for ON_TICKS cycles
//   ST_GAP  | LED forced off for GAP_TICKS cycles
// -----------------------------------------------------------------------------
module pulse_stretch_led
    import pulse_stretch_led_pkg::*;
#(
    parameter int ON_TICKS    = 20,
    parameter int GAP_TICKS   = 10,
    parameter int MAX_PENDING = 7,
    parameter int PW          = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk_200H,
    input  logic          rst_n,
    input  logic          pulse_in,
    output logic          led_out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow
`ifdef PULSE_STRETCH_OVF_CLR_EN
    ,
    input  logic          ovf_clr
`endif
);

    localparam int CW = cnt_width(ON_TICKS, GAP_TICKS);

    logic [1:0]    r_state;
    logic          r_led;
    logic          r_busy;
    logic [PW-1:0] r_pending;
    logic          r_ovf;

    logic [1:0]    w_state_nxt;
    logic          w_load;
    logic          w_en;
    logic          w_last;
    logic [CW-1:0] w_limit;
    logic          w_inc;
    logic          w_dec;
    logic          w_ovf_set;
    logic          w_ovf_clr;

    // One counter serves both phases; the limit follows the current state.
    assign w_limit = (r_state == ST_GAP) ? CW'(GAP_TICKS) : CW'(ON_TICKS);
    assign w_en    = (r_state != ST_IDLE);

    hold_counter #(
        .W (CW)
    ) u_hold_counter (
        .clk     (clk_200H),
        .rst_n   (rst_n),
        .i_en    (w_en),
        .i_load  (w_load),
        .i_limit (w_limit),
        .o_last  (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Counter held at 0 so ON starts from a clean count.
                w_load = 1'b1;
                if (pulse_in) begin
                    w_state_nxt = ST_ON;
                end
            end
            ST_ON: begin
                w_inc = pulse_in;
                if (w_last) begin
                    w_state_nxt = ST_GAP;
                    w_load      = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_last) begin
                    w_load = 1'b1;
                    if (r_pending != '0) begin
                        w_state_nxt = ST_ON;
                        w_dec       = 1'b1;
                        w_inc       = pulse_in;
                    end else if (pulse_in) begin
                        // Queue empty: the new event is shown directly.
                        w_state_nxt = ST_ON;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_inc = pulse_in;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_load      = 1'b1;
            end
        endcase
    end

    assign w_ovf_set = w_inc && !w_dec && (r_pending == PW'(MAX_PENDING));

`ifdef PULSE_STRETCH_OVF_CLR_EN
    assign w_ovf_clr = ovf_clr;
`else
    assign w_ovf_clr = 1'b0;
`endif

    always_ff @(posedge clk_200H) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_led     <= 1'b0;
            r_busy    <= 1'b0;
            r_pending <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_led   <= (w_state_nxt == ST_ON);
            r_busy  <= (w_state_nxt != ST_IDLE);

            // Simultaneous increment and decrement leave the queue unchanged.
            if (w_inc && !w_dec) begin
                if (r_pending != PW'(MAX_PENDING)) begin
                    r_pending <= r_pending + PW'(1);
                end
            end else if (w_dec && !w_inc) begin
                r_pending <= r_pending - PW'(1);
            end

            // A new overflow in the same cycle as a clear keeps the flag set.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign led_out  = r_led;
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_pulse_stretch_led.sv
// Directed bench for pulse_stretch_led with ON_TICKS=4, GAP_TICKS=2,
// MAX_PENDING=3. Cycle c begins at rising edge c; outputs are sampled 1 ns
// after that edge and inputs for cycle c are driven right after sampling.
module tb_pulse_stretch_led;

    logic       clk_200H = 1'b0;
    logic       rst_n    = 1'b0;
    logic       pulse_in = 1'b0;
    logic       ovf_clr  = 1'b0;
    logic       led_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    pulse_stretch_led #(
        .ON_TICKS    (4),
        .GAP_TICKS   (2),
        .MAX_PENDING (3)
    ) dut (
        .clk_200H (clk_200H),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .led_out  (led_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
`ifdef PULSE_STRETCH_OVF_CLR_EN
        ,
        .ovf_clr  (ovf_clr)
`endif
    );

    always #5 clk_200H = ~clk_200H;

    function automatic logic [39:0] rng(input int lo, input int hi);
        logic [39:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Scenario 1: reset held 3 cycles with pulse_in high, nothing starts.
    task automatic test_reset();
        logic [39:0] stim, rstv;
        logic [4:0]  got;
        stim = rng(0, 2);
        rstv = rng(0, 2);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_200H); #1;
            if (c >= 1) begin
                got = {led_out, busy, pending, overflow};
                checks++;
                if (got !== 5'b0) begin
                    errors++;
                    $display("FAIL reset c=%0d got=%b exp=%b", c, got, 5'b0);
                end
            end
            pulse_in = stim[c];
            rst_n    = ~rstv[c];
        end
    endtask

    // Scenario 2: single pulse at cycle 10.
    task automatic test_single();
        logic [39:0] stim, rstv, el, eb;
        logic [4:0]  got, exp;
        stim = rng(10, 10);
        rstv = rng(0, 2);
        el   = rng(11, 14);
        eb   = rng(11, 16);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_200H); #1;
            if (c >= 1) begin
                got = {led_out, busy, pending, overflow};
                exp = {el[c], eb[c], 2'd0, 1'b0};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL single c=%0d got=%b exp=%b", c, got, exp);
                end
            end
            pulse_in = stim[c];
            rst_n    = ~rstv[c];
        end
    endtask

    // Scenario 3: pulses at 10 and 12, second one queued.
    task automatic test_queue();
        logic [39:0] stim, rstv, el, eb;
        logic [1:0]  ep [40];
        logic [4:0]  got, exp;
        stim = rng(10, 10) | rng(12, 12);
        rstv = rng(0, 2);
        el   = rng(11, 14) | rng(17, 20);
        eb   = rng(11, 22);
        for (int i = 0; i < 40; i++) ep[i] = (i >= 13 && i <= 16) ? 2'd1 : 2'd0;
        for (int c = 0; c < 26; c++) begin
            @(posedge clk_200H); #1;
            if (c >= 1) begin
                got = {led_out, busy, pending, overflow};
                exp = {el[c], eb[c], ep[c], 1'b0};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL queue c=%0d got=%b exp=%b", c, got, exp);
                end
            end
            pulse_in = stim[c];
            rst_n    = ~rstv[c];
        end
    endtask

    // Scenario 4 (and 7 with the clear option): pulses 10..15, queue saturates.
    task automatic test_saturate(input bit use_clr);
        logic [39:0] stim, rstv, clrv, el, eb, eo;
        logic [1:0]  ep [40];
        logic [4:0]  got, exp;
        stim = rng(10, 15);
        rstv = rng(0, 2);
        clrv = use_clr ? rng(20, 20) : 40'd0;
        el   = rng(11, 14) | rng(17, 20) | rng(23, 26) | rng(29, 32);
        eb   = rng(11, 34);
        eo   = use_clr ? rng(15, 20) : rng(15, 39);
        for (int i = 0; i < 40; i++) begin
            if (i == 12)                 ep[i] = 2'd1;
            else if (i == 13)            ep[i] = 2'd2;
            else if (i >= 14 && i <= 16) ep[i] = 2'd3;
            else if (i >= 17 && i <= 22) ep[i] = 2'd2;
            else if (i >= 23 && i <= 28) ep[i] = 2'd1;
            else                         ep[i] = 2'd0;
        end
        for (int c = 0; c < 38; c++) begin
            @(posedge clk_200H); #1;
            if (c >= 1) begin
                got = {led_out, busy, pending, overflow};
                exp = {el[c], eb[c], ep[c], eo[c]};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL saturate clr=%0d c=%0d got=%b exp=%b", use_clr, c, got, exp);
                end
            end
            pulse_in = stim[c];
            rst_n    = ~rstv[c];
            ovf_clr  = clrv[c];
        end
        ovf_clr = 1'b0;
    endtask

    // Scenario 5: pulse on the GAP-end cycle with an empty queue starts ON directly.
    task automatic test_back_to_back();
        logic [39:0] stim, rstv, el, eb;
        logic [4:0]  got, exp;
        stim = rng(10, 10) | rng(16, 16);
        rstv = rng(0, 2);
        el   = rng(11, 14) | rng(17, 20);
        eb   = rng(11, 22);
        for (int c = 0; c < 26; c++) begin
            @(posedge clk_200H); #1;
            if (c >= 1) begin
                got = {led_out, busy, pending, overflow};
                exp = {el[c], eb[c], 2'd0, 1'b0};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL gap_end c=%0d got=%b exp=%b", c, got, exp);
                end
            end
            pulse_in = stim[c];
            rst_n    = ~rstv[c];
        end
    endtask

    // Scenario 6: reset in cycle 12 while pending=2 discards everything.
    task automatic test_mid_reset();
        logic [39:0] stim, rstv, el, eb;
        logic [1:0]  ep [40];
        logic [4:0]  got, exp;
        stim = rng(9, 12);
        rstv = rng(0, 2) | rng(12, 12);
        el   = rng(10, 12);
        eb   = rng(10, 12);
        for (int i = 0; i < 40; i++) ep[i] = (i == 11) ? 2'd1 : ((i == 12) ? 2'd2 : 2'd0);
        for (int c = 0; c < 22; c++) begin
            @(posedge clk_200H); #1;
            if (c >= 1) begin
                got = {led_out, busy, pending, overflow};
                exp = {el[c], eb[c], ep[c], 1'b0};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL mid_reset c=%0d got=%b exp=%b", c, got, exp);
                end
            end
            pulse_in = stim[c];
            rst_n    = ~rstv[c];
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue();
        test_saturate(1'b0);
        test_back_to_back();
        test_mid_reset();
`ifdef PULSE_STRETCH_OVF_CLR_EN
        test_saturate(1'b1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
